// File: rtl/dac_frame_scheduler.sv
// Paces two sample sinks into one channel-tagged Avalon-ST source, A then B per frame.
// Ports: clk/reset, enable, asiA*/asiB* sinks, aso* source, underrunA/B and frameMiss pulses.
module dac_frame_scheduler #(
  parameter int DATA_WIDTH = 14,
  parameter int PERIOD     = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  asiAValid,
  input  logic [DATA_WIDTH-1:0] asiAData,
  output logic                  asiARdy,
  input  logic                  asiBValid,
  input  logic [DATA_WIDTH-1:0] asiBData,
  output logic                  asiBRdy,
  output logic                  asoValid,
  output logic                  asoChannel,
  output logic [DATA_WIDTH-1:0] asoData,
  input  logic                  asoRdy,
  output logic                  underrunA,
  output logic                  underrunB,
  output logic                  frameMiss
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [DATA_WIDTH-1:0] reg_a, reg_b;
  logic                  fresh_a, fresh_b;
  logic                  fresh_a_nxt, fresh_b_nxt;
  logic                  acc_a, acc_b;
  logic                  hs_a, hs_b;

  assign tick  = enable && (cnt == LAST);
  assign acc_a = asiAValid && asiARdy;
  assign acc_b = asiBValid && asiBRdy;
  assign hs_a  = (state == SEND_A) && asoRdy;
  assign hs_b  = (state == SEND_B) && asoRdy;

  // A new sample arriving while the stale one is sent wins: it is the
  // freshest data and must not be lost.
  assign fresh_a_nxt = acc_a ? 1'b1 : (hs_a ? 1'b0 : fresh_a);
  assign fresh_b_nxt = acc_b ? 1'b1 : (hs_b ? 1'b0 : fresh_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      fresh_a <= 1'b0;
      fresh_b <= 1'b0;
      asiARdy <= 1'b0;
      asiBRdy <= 1'b0;
    end else begin
      if (acc_a) reg_a <= asiAData;
      if (acc_b) reg_b <= asiBData;
      fresh_a <= fresh_a_nxt;
      fresh_b <= fresh_b_nxt;
      // Ready registered from next-state fresh so it tracks fresh exactly.
      asiARdy <= !fresh_a_nxt;
      asiBRdy <= !fresh_b_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrunA <= 1'b0;
      underrunB <= 1'b0;
      frameMiss <= 1'b0;
    end else begin
      underrunA <= hs_a && !fresh_a;
      underrunB <= hs_b && !fresh_b;
      frameMiss <= tick && (state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    asoValid   = 1'b0;
    asoChannel = 1'b0;
    asoData    = '0;
    unique case (state)
      IDLE: begin
        if (tick) state_nxt = SEND_A;
      end
      SEND_A: begin
        asoValid = 1'b1;
        asoData  = reg_a;
        if (asoRdy) state_nxt = SEND_B;
      end
      SEND_B: begin
        asoValid   = 1'b1;
        asoChannel = 1'b1;
        asoData    = reg_b;
        if (asoRdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler.
// Expected words are queued at feed time and popped on each source handshake.
module tb_dac_frame_scheduler;

  localparam int DW = 14;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          asiAValid = 1'b0;
  logic [DW-1:0] asiAData = '0;
  logic          asiARdy;
  logic          asiBValid = 1'b0;
  logic [DW-1:0] asiBData = '0;
  logic          asiBRdy;
  logic          asoValid;
  logic          asoChannel;
  logic [DW-1:0] asoData;
  logic          asoRdy = 1'b1;
  logic          underrunA;
  logic          underrunB;
  logic          frameMiss;

  dac_frame_scheduler #(.DATA_WIDTH(DW), .PERIOD(P)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .asiAValid(asiAValid),
    .asiAData(asiAData),
    .asiARdy(asiARdy),
    .asiBValid(asiBValid),
    .asiBData(asiBData),
    .asiBRdy(asiBRdy),
    .asoValid(asoValid),
    .asoChannel(asoChannel),
    .asoData(asoData),
    .asoRdy(asoRdy),
    .underrunA(underrunA),
    .underrunB(underrunB),
    .frameMiss(frameMiss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] data;
    logic          und;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int miss_cnt = 0, ua_cnt = 0, ub_cnt = 0;
  int acc_a_cnt = 0, acc_bad = 0, hs_edge = 0;
  int last_a = 0, a_gap = 0;
  bit track = 0;
  bit pend = 0;
  logic pend_ch, pend_und, prev_v = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0;
      prev_v = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if ((pend_ch ? underrunB : underrunA) !== pend_und)
          $display("FAIL underrun ch%0d got %b want %b", pend_ch,
                   pend_ch ? underrunB : underrunA, pend_und);
        else passed++;
        pend = 0;
      end
      if (frameMiss === 1'b1) miss_cnt++;
      if (underrunA === 1'b1) ua_cnt++;
      if (underrunB === 1'b1) ub_cnt++;
      if (asiAValid && asiARdy === 1'b1) begin
        acc_a_cnt++;
        if (track && (cyc + 1 != hs_edge + 1)) acc_bad++;
      end
      if (asoValid === 1'b1 && asoChannel === 1'b0 && !prev_v) begin
        a_gap = cyc - last_a;
        last_a = cyc;
      end
      if (asoValid === 1'b1 && asoRdy) begin
        if (!asoChannel) hs_edge = cyc + 1;
        checks++;
        if (q.size() == 0) begin
          $display("FAIL word unexpected ch%0d data %h", asoChannel, asoData);
        end else begin
          e = q.pop_front();
          if (asoChannel !== e.ch || asoData !== e.data)
            $display("FAIL word got ch%0d %h want ch%0d %h",
                     asoChannel, asoData, e.ch, e.data);
          else passed++;
          pend = 1;
          pend_ch = e.ch;
          pend_und = e.und;
        end
      end
      prev_v = asoValid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [DW-1:0] d, input logic u);
    q.push_back({ch, d, u});
  endtask

  task automatic wait_valid(input logic lvl);
    int n = 0;
    while (asoValid !== lvl && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL timeout asoValid got %b want %b", asoValid, lvl);
    end
  endtask

  task automatic wait_frame();
    wait_valid(1'b1);
    wait_valid(1'b0);
  endtask

  task automatic feed(input logic ch, input logic [DW-1:0] d);
    int n = 0;
    if (ch) begin asiBValid = 1'b1; asiBData = d; end
    else    begin asiAValid = 1'b1; asiAData = d; end
    while ((ch ? asiBRdy : asiARdy) !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL timeout feed ch%0d rdy stuck low", ch);
    end
    step();
    if (ch) asiBValid = 1'b0;
    else    asiAValid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks += 6;
    if (asoValid !== 1'b0) $display("FAIL rst_valid got %b want 0", asoValid); else passed++;
    if (asoChannel !== 1'b0) $display("FAIL rst_chan got %b want 0", asoChannel); else passed++;
    if (asoData !== '0) $display("FAIL rst_data got %h want 0", asoData); else passed++;
    if ({asiARdy, asiBRdy} !== 2'b00)
      $display("FAIL rst_rdy got %b want 00", {asiARdy, asiBRdy}); else passed++;
    if ({underrunA, underrunB} !== 2'b00)
      $display("FAIL rst_und got %b want 00", {underrunA, underrunB}); else passed++;
    if (frameMiss !== 1'b0) $display("FAIL rst_miss got %b want 0", frameMiss); else passed++;
    reset = 1'b0;
    step();
    checks++;
    if ({asiARdy, asiBRdy} !== 2'b11)
      $display("FAIL rel_rdy got %b want 11", {asiARdy, asiBRdy}); else passed++;
  endtask

  task automatic test_basic();
    int n = 0;
    feed(1'b0, 14'h100);
    feed(1'b1, 14'h200);
    push(1'b0, 14'h100, 1'b0);
    push(1'b1, 14'h200, 1'b0);
    enable = 1'b1;
    while (asoValid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n != P) $display("FAIL first_frame got %0d clocks want %0d", n, P); else passed++;
    wait_valid(1'b0);
    feed(1'b0, 14'h101);
    feed(1'b1, 14'h201);
    push(1'b0, 14'h101, 1'b0);
    push(1'b1, 14'h201, 1'b0);
    wait_frame();
    checks += 3;
    if (a_gap != P) $display("FAIL frame_gap got %0d want %0d", a_gap, P); else passed++;
    if (miss_cnt + ua_cnt + ub_cnt != 0)
      $display("FAIL basic_flags got %0d want 0", miss_cnt + ua_cnt + ub_cnt); else passed++;
    if (q.size() != 0) $display("FAIL basic_drain got %0d want 0", q.size()); else passed++;
  endtask

  task automatic test_underrun();
    int ua0 = ua_cnt, ub0 = ub_cnt;
    feed(1'b0, 14'h3FFF);
    feed(1'b1, 14'h300);
    push(1'b0, 14'h3FFF, 1'b0);
    push(1'b1, 14'h300, 1'b0);
    wait_frame();
    for (int i = 0; i < 2; i++) begin
      feed(1'b1, 14'h301 + 14'(i));
      push(1'b0, 14'h3FFF, 1'b1);
      push(1'b1, 14'h301 + 14'(i), 1'b0);
      wait_frame();
    end
    checks += 2;
    if (ua_cnt - ua0 != 2) $display("FAIL und_a_cnt got %0d want 2", ua_cnt - ua0); else passed++;
    if (ub_cnt - ub0 != 0) $display("FAIL und_b_cnt got %0d want 0", ub_cnt - ub0); else passed++;
  endtask

  task automatic test_backpressure();
    int m0 = miss_cnt;
    bit stable = 1;
    asoRdy = 1'b0;
    feed(1'b0, 14'h0AA);
    feed(1'b1, 14'h0BB);
    push(1'b0, 14'h0AA, 1'b0);
    push(1'b1, 14'h0BB, 1'b0);
    wait_valid(1'b1);
    repeat (12) begin
      if (!(asoValid === 1'b1 && asoChannel === 1'b0 && asoData === 14'h0AA)) stable = 0;
      step();
    end
    checks++;
    if (!stable) $display("FAIL bp_hold got ch%0d %h want ch0 0aa", asoChannel, asoData); else passed++;
    asoRdy = 1'b1;
    wait_valid(1'b0);
    checks += 2;
    if (miss_cnt - m0 != 1) $display("FAIL frame_miss got %0d want 1", miss_cnt - m0); else passed++;
    if (q.size() != 0) $display("FAIL bp_drain got %0d want 0", q.size()); else passed++;
  endtask

  task automatic test_enable();
    int n = 0;
    bit idle = 1;
    feed(1'b0, 14'h0C1);
    feed(1'b1, 14'h0C2);
    push(1'b0, 14'h0C1, 1'b0);
    push(1'b1, 14'h0C2, 1'b0);
    while (!(asoValid === 1'b1 && asoChannel === 1'b1) && n < 200) begin
      step();
      n++;
    end
    enable = 1'b0;
    wait_valid(1'b0);
    checks++;
    if (q.size() != 0) $display("FAIL en_b_sent got %0d left want 0", q.size()); else passed++;
    repeat (30) begin
      if (asoValid !== 1'b0) idle = 0;
      step();
    end
    checks++;
    if (!idle) $display("FAIL en_idle got valid 1 want 0"); else passed++;
    push(1'b0, 14'h0C1, 1'b1);
    push(1'b1, 14'h0C2, 1'b1);
    enable = 1'b1;
    n = 0;
    while (asoValid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n != P) $display("FAIL reenable got %0d clocks want %0d", n, P); else passed++;
    wait_valid(1'b0);
  endtask

  task automatic test_reset_mid();
    int ua0 = ua_cnt, ub0 = ub_cnt;
    asoRdy = 1'b0;
    feed(1'b0, 14'h155);
    feed(1'b1, 14'h266);
    wait_valid(1'b1);
    #1 reset = 1'b1;
    #1;
    checks += 2;
    if (asoValid !== 1'b0) $display("FAIL rm_valid got %b want 0", asoValid); else passed++;
    if (asoData !== '0) $display("FAIL rm_data got %h want 0", asoData); else passed++;
    step();
    step();
    reset = 1'b0;
    asoRdy = 1'b1;
    push(1'b0, 14'h000, 1'b1);
    push(1'b1, 14'h000, 1'b1);
    step();
    checks++;
    if (asiARdy !== 1'b1) $display("FAIL rm_rdy got %b want 1", asiARdy); else passed++;
    wait_frame();
    checks += 2;
    if (ua_cnt - ua0 != 1) $display("FAIL rm_und_a got %0d want 1", ua_cnt - ua0); else passed++;
    if (ub_cnt - ub0 != 1) $display("FAIL rm_und_b got %0d want 1", ub_cnt - ub0); else passed++;
  endtask

  task automatic test_sink_handshake();
    int a0 = acc_a_cnt;
    asiAValid = 1'b1;
    asiAData = 14'h1A0;
    step();
    step();
    track = 1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 14'h1A0, 1'b0);
      push(1'b1, 14'h000, 1'b1);
      wait_frame();
    end
    asiAValid = 1'b0;
    track = 0;
    checks += 3;
    if (acc_a_cnt - a0 != 4) $display("FAIL sink_accepts got %0d want 4", acc_a_cnt - a0); else passed++;
    if (acc_bad != 0) $display("FAIL sink_timing got %0d late want 0", acc_bad); else passed++;
    if (q.size() != 0) $display("FAIL sink_drain got %0d want 0", q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_sink_handshake();
    enable = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
